// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter
// Merges the instruction-fetch and data-access SRAM-like request ports onto
// one shared SRAM-like master port. A small owner FIFO remembers who issued
// each accepted transaction so in-order responses are steered back correctly.
// Compile-time option: define ARB_RR_EN for round-robin arbitration on
// contention; otherwise data has fixed priority over inst.

module sram_port_arbiter #(
  parameter int MAX_OUTSTANDING = 2  // owner FIFO depth: 1, 2 or 4
) (
  input  logic        clk,
  input  logic        reset,

  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [3:0]  inst_wstrb,
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,

  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,

  output logic        mem_req,
  output logic        mem_wr,
  output logic [1:0]  mem_size,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata,

  output logic        busy
);

  localparam int CNT_W = $clog2(MAX_OUTSTANDING) + 1;
  localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

  typedef enum logic {
    OWN_INST = 1'b0,
    OWN_DATA = 1'b1
  } owner_e;

  logic                       lock_v;
  owner_e                     lock_own;
  logic [MAX_OUTSTANDING-1:0] own_fifo;
  logic [PTR_W-1:0]           wr_ptr;
  logic [PTR_W-1:0]           rd_ptr;
  logic [CNT_W-1:0]           cnt;
  logic [CNT_W-1:0]           cnt_nxt;
`ifdef ARB_RR_EN
  owner_e                     rr_last;
`endif

  owner_e winner;
  owner_e head_own;
  logic   win_req;
  logic   full;
  logic   push;
  logic   pop;

  // Advance a FIFO pointer, wrapping at the configured depth.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Pick the winning requester: a held lock first, then the contention policy.
  always_comb begin
    // NOTE: every always_comb output gets a default before any branch so no
    // path leaves it unassigned, which would infer a latch.
    winner = OWN_INST;
    if (lock_v) begin
      winner = lock_own;
    end else if (inst_req && data_req) begin
`ifdef ARB_RR_EN
      winner = (rr_last == OWN_INST) ? OWN_DATA : OWN_INST;
`else
      winner = OWN_DATA;
`endif
    end else if (data_req) begin
      winner = OWN_DATA;
    end
  end

  // Master-port request, handshake qualifiers and response steering.
  always_comb begin
    win_req  = (winner == OWN_DATA) ? data_req : inst_req;
    full     = (cnt == CNT_W'(MAX_OUTSTANDING));
    mem_req  = win_req && !full && !reset;
    push     = mem_req && mem_addr_ok;
    pop      = mem_data_ok && (cnt != '0) && !reset;
    head_own = owner_e'(own_fifo[rd_ptr]);

    inst_addr_ok = push && (winner == OWN_INST);
    data_addr_ok = push && (winner == OWN_DATA);
    inst_data_ok = pop && (head_own == OWN_INST);
    data_data_ok = pop && (head_own == OWN_DATA);
    inst_rdata   = mem_rdata;
    data_rdata   = mem_rdata;

    busy = !reset && ((cnt != '0) || lock_v);

    unique case ({push, pop})
      2'b10:   cnt_nxt = cnt + CNT_W'(1);
      2'b01:   cnt_nxt = cnt - CNT_W'(1);
      default: cnt_nxt = cnt;
    endcase
  end

  // Request fields follow the winner whether or not mem_req is raised.
  always_comb begin
    if (winner == OWN_DATA) begin
      mem_wr    = data_wr;
      mem_size  = data_size;
      mem_wstrb = data_wstrb;
      mem_addr  = data_addr;
      mem_wdata = data_wdata;
    end else begin
      mem_wr    = inst_wr;
      mem_size  = inst_size;
      mem_wstrb = inst_wstrb;
      mem_addr  = inst_addr;
      mem_wdata = inst_wdata;
    end
  end

  // Control state: grant lock, FIFO pointers, occupancy and round-robin history.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      lock_v   <= 1'b0;
      lock_own <= OWN_INST;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      cnt      <= '0;
`ifdef ARB_RR_EN
      rr_last  <= OWN_INST;
`endif
    end else begin
      if (lock_v && !win_req) begin
        lock_v <= 1'b0;  // locked owner withdrew its request
      end else if (push) begin
        lock_v <= 1'b0;
      end else if (mem_req) begin
        lock_v   <= 1'b1;
        lock_own <= winner;
      end

      if (push) begin
        wr_ptr <= ptr_inc(wr_ptr);
`ifdef ARB_RR_EN
        rr_last <= winner;
`endif
      end
      if (pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      cnt <= cnt_nxt;
    end
  end

  // Owner FIFO storage: one bit per entry recording who issued the request.
  always_ff @(posedge clk) begin
    // NOTE: the storage array is deliberately not reset; an entry is only read
    // after it has been written, and cnt/pointers carry all reset state.
    if (push) begin
      own_fifo[wr_ptr] <= winner;
    end
  end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb_sram_port_arbiter
// Directed bench for sram_port_arbiter (MAX_OUTSTANDING = 2). Inputs change on
// the falling edge and outputs are sampled 1 ns later, away from the rising edge.

module tb_sram_port_arbiter;

  logic        clk;
  logic        reset;
  logic        inst_req, inst_wr;
  logic [1:0]  inst_size;
  logic [3:0]  inst_wstrb;
  logic [31:0] inst_addr, inst_wdata;
  logic        inst_addr_ok, inst_data_ok;
  logic [31:0] inst_rdata;
  logic        data_req, data_wr;
  logic [1:0]  data_size;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr, data_wdata;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;
  logic        mem_req, mem_wr;
  logic [1:0]  mem_size;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_addr_ok, mem_data_ok;
  logic [31:0] mem_rdata;
  logic        busy;

  int n_cmp = 0;
  int n_err = 0;

  sram_port_arbiter #(.MAX_OUTSTANDING(2)) dut (
    .clk(clk), .reset(reset),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
    .inst_wstrb(inst_wstrb), .inst_addr(inst_addr), .inst_wdata(inst_wdata),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_wstrb(data_wstrb), .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_wstrb(mem_wstrb),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok),
    .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Move to the next falling edge, where new stimulus is applied.
  task automatic step();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    inst_req = 0; inst_wr = 0; inst_size = 2'd2; inst_wstrb = 4'h0;
    inst_addr = 32'h0; inst_wdata = 32'h0;
    data_req = 0; data_wr = 0; data_size = 2'd2; data_wstrb = 4'h0;
    data_addr = 32'h0; data_wdata = 32'h0;
    mem_addr_ok = 0; mem_data_ok = 0; mem_rdata = 32'h0;
  endtask

  // Watchdog: the directed sequence is short; anything longer is a hang.
  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    idle_inputs();
    reset = 1;

    // ---- Reset: outputs forced low even with live inputs ----
    step();
    inst_req = 1; inst_addr = 32'h1c00_0000; mem_addr_ok = 1; mem_data_ok = 1;
    #1;
    check("rst_mem_req", 32'(mem_req), 0);
    check("rst_inst_addr_ok", 32'(inst_addr_ok), 0);
    check("rst_inst_data_ok", 32'(inst_data_ok), 0);
    check("rst_busy", 32'(busy), 0);
    step();
    idle_inputs();
    reset = 0;
    #1;
    check("rst_cnt", 32'(dut.cnt), 0);
    check("rst_busy_after", 32'(busy), 0);

    // ---- Test 1: single inst read ----
    step();
    inst_req = 1; inst_addr = 32'h1c00_0000; mem_addr_ok = 1;
    #1;
    check("t1_mem_req", 32'(mem_req), 1);
    check("t1_mem_addr", mem_addr, 32'h1c00_0000);
    check("t1_mem_wr", 32'(mem_wr), 0);
    check("t1_inst_addr_ok", 32'(inst_addr_ok), 1);
    check("t1_data_addr_ok", 32'(data_addr_ok), 0);
    step();
    inst_req = 0; mem_addr_ok = 0;
    #1;
    check("t1_busy", 32'(busy), 1);
    check("t1_mem_req_idle", 32'(mem_req), 0);
    check("t1_inst_data_ok_early", 32'(inst_data_ok), 0);
    step();
    mem_data_ok = 1; mem_rdata = 32'h0280_0c0c;
    #1;
    check("t1_inst_data_ok", 32'(inst_data_ok), 1);
    check("t1_inst_rdata", inst_rdata, 32'h0280_0c0c);
    check("t1_data_data_ok", 32'(data_data_ok), 0);
    step();
    mem_data_ok = 0;
    #1;
    check("t1_cnt_end", 32'(dut.cnt), 0);
    check("t1_busy_end", 32'(busy), 0);

    // ---- Test 2: contention, data store wins first ----
    step();
    idle_inputs();
    inst_req = 1; inst_addr = 32'h1c00_0004;
    data_req = 1; data_wr = 1; data_addr = 32'h8000_0010; data_wstrb = 4'hF;
    data_wdata = 32'hdead_beef;
    mem_addr_ok = 1;
    #1;
    check("t2_mem_wr_data", 32'(mem_wr), 1);
    check("t2_mem_addr_data", mem_addr, 32'h8000_0010);
    check("t2_mem_wstrb", 32'(mem_wstrb), 32'hF);
    check("t2_mem_wdata", mem_wdata, 32'hdead_beef);
    check("t2_data_addr_ok", 32'(data_addr_ok), 1);
    check("t2_inst_addr_ok_lose", 32'(inst_addr_ok), 0);
    step();
    data_req = 0;
    #1;
    check("t2_mem_addr_inst", mem_addr, 32'h1c00_0004);
    check("t2_mem_wr_inst", 32'(mem_wr), 0);
    check("t2_inst_addr_ok", 32'(inst_addr_ok), 1);
    check("t2_data_addr_ok_2", 32'(data_addr_ok), 0);
    step();
    inst_req = 0; mem_addr_ok = 0; mem_data_ok = 1; mem_rdata = 32'h0;
    #1;
    check("t2_cnt_full", 32'(dut.cnt), 2);
    check("t2_data_data_ok", 32'(data_data_ok), 1);
    check("t2_inst_data_ok_0", 32'(inst_data_ok), 0);
    step();
    mem_rdata = 32'h1111_2222;
    #1;
    check("t2_inst_data_ok", 32'(inst_data_ok), 1);
    check("t2_data_data_ok_0", 32'(data_data_ok), 0);
    check("t2_inst_rdata", inst_rdata, 32'h1111_2222);
    step();
    mem_data_ok = 0;
    #1;
    check("t2_cnt_end", 32'(dut.cnt), 0);

`ifdef ARB_RR_EN
    // ---- Test 3: round-robin, both held for 4 acceptances ----
    for (int i = 0; i < 4; i++) begin
      step();
      idle_inputs();
      inst_req = 1; inst_addr = 32'h1c00_0300;
      data_req = 1; data_addr = 32'h8000_0040;
      mem_addr_ok = 1; mem_data_ok = (i > 0);
      #1;
      check($sformatf("t3_mem_addr_%0d", i), mem_addr,
            (i % 2 == 0) ? 32'h8000_0040 : 32'h1c00_0300);
      check($sformatf("t3_data_addr_ok_%0d", i), 32'(data_addr_ok), (i % 2 == 0) ? 1 : 0);
      check($sformatf("t3_inst_addr_ok_%0d", i), 32'(inst_addr_ok), (i % 2 == 1) ? 1 : 0);
      if (i > 0)
        check($sformatf("t3_data_data_ok_%0d", i), 32'(data_data_ok), (i % 2 == 1) ? 1 : 0);
    end
    step();
    idle_inputs();
    mem_data_ok = 1;
    #1;
    check("t3_drain_inst_data_ok", 32'(inst_data_ok), 1);
    step();
    mem_data_ok = 0;
    #1;
    check("t3_cnt_end", 32'(dut.cnt), 0);
`endif

    // ---- Test 4: lock holds inst while addr_ok is low ----
    step();
    idle_inputs();
    inst_req = 1; inst_addr = 32'h1c00_0100;
    #1;
    check("t4_c0_mem_addr", mem_addr, 32'h1c00_0100);
    check("t4_c0_inst_addr_ok", 32'(inst_addr_ok), 0);
    step();
    data_req = 1; data_addr = 32'h8000_0020;
    #1;
    check("t4_c1_mem_addr", mem_addr, 32'h1c00_0100);
    check("t4_c1_data_addr_ok", 32'(data_addr_ok), 0);
    check("t4_c1_busy", 32'(busy), 1);
    step();
    #1;
    check("t4_c2_mem_addr", mem_addr, 32'h1c00_0100);
    check("t4_c2_mem_req", 32'(mem_req), 1);
    step();
    mem_addr_ok = 1;
    #1;
    check("t4_c3_mem_addr", mem_addr, 32'h1c00_0100);
    check("t4_c3_inst_addr_ok", 32'(inst_addr_ok), 1);
    check("t4_c3_data_addr_ok", 32'(data_addr_ok), 0);
    step();
    inst_req = 0;
    #1;
    check("t4_c4_mem_addr", mem_addr, 32'h8000_0020);
    check("t4_c4_data_addr_ok", 32'(data_addr_ok), 1);
    step();
    data_req = 0; mem_addr_ok = 0; mem_data_ok = 1;
    #1;
    check("t4_resp_inst", 32'(inst_data_ok), 1);
    step();
    #1;
    check("t4_resp_data", 32'(data_data_ok), 1);
    step();
    mem_data_ok = 0;
    #1;
    check("t4_cnt_end", 32'(dut.cnt), 0);

    // ---- Test 5: fill to MAX_OUTSTANDING, then pop with a pending request ----
    step();
    idle_inputs();
    inst_req = 1; inst_addr = 32'h1c00_0200; mem_addr_ok = 1;
    #1;
    check("t5_a_inst_addr_ok", 32'(inst_addr_ok), 1);
    step();
    inst_addr = 32'h1c00_0204;
    #1;
    check("t5_b_inst_addr_ok", 32'(inst_addr_ok), 1);
    step();
    inst_req = 0; data_req = 1; data_addr = 32'h8000_0030;
    #1;
    check("t5_c_cnt", 32'(dut.cnt), 2);
    check("t5_c_mem_req_full", 32'(mem_req), 0);
    check("t5_c_data_addr_ok", 32'(data_addr_ok), 0);
    step();
    mem_data_ok = 1;
    #1;
    check("t5_d_mem_req_full_pop", 32'(mem_req), 0);
    check("t5_d_inst_data_ok", 32'(inst_data_ok), 1);
    check("t5_d_data_addr_ok", 32'(data_addr_ok), 0);
    step();
    mem_data_ok = 0;
    #1;
    check("t5_e_cnt", 32'(dut.cnt), 1);
    check("t5_e_mem_req", 32'(mem_req), 1);
    check("t5_e_data_addr_ok", 32'(data_addr_ok), 1);
    check("t5_e_mem_addr", mem_addr, 32'h8000_0030);
    step();
    data_req = 0; mem_addr_ok = 0; mem_data_ok = 1;
    #1;
    check("t5_f_cnt", 32'(dut.cnt), 2);
    check("t5_f_inst_data_ok", 32'(inst_data_ok), 1);

    // ---- Test 6: reset with one data entry outstanding, then a stray response ----
    step();
    mem_data_ok = 0; reset = 1;
    data_req = 1; mem_addr_ok = 1;
    #1;
    check("t6_pre_cnt", 32'(dut.cnt), 1);
    check("t6_rst_busy", 32'(busy), 0);
    check("t6_rst_mem_req", 32'(mem_req), 0);
    check("t6_rst_data_addr_ok", 32'(data_addr_ok), 0);
    step();
    reset = 0; data_req = 0; mem_addr_ok = 0; mem_data_ok = 1;
    #1;
    check("t6_spur_data_data_ok", 32'(data_data_ok), 0);
    check("t6_spur_inst_data_ok", 32'(inst_data_ok), 0);
    check("t6_spur_busy", 32'(busy), 0);
    step();
    mem_data_ok = 0;
    #1;
    check("t6_cnt_end", 32'(dut.cnt), 0);
    check("t6_busy_end", 32'(busy), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sram_port_arbiter.md
# sram_port_arbiter

Arbitrates the core's instruction-fetch and data-access SRAM-like request ports onto a single shared SRAM-like master port, ahead of the AXI bridge. It tracks up to `MAX_OUTSTANDING` accepted-but-unanswered transactions in an owner FIFO, and routes each in-order response back to the requester that issued it. Grant is locked while a presented request waits for `addr_ok`, so the downstream side sees a stable request.

## Interface

**Parameters**
- `MAX_OUTSTANDING`, default 2: owner-FIFO depth. Legal values are 1, 2 or 4.

**Ports**
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high reset.
- `inst_req`, `inst_wr` in 1 each: instruction requester's valid and write flag.
- `inst_size` in 2, `inst_wstrb` in 4, `inst_addr` in 32, `inst_wdata` in 32: instruction request fields.
- `inst_addr_ok`, `inst_data_ok` out 1 each; `inst_rdata` out 32.
- `data_req`, `data_wr` in 1 each; `data_size` in 2, `data_wstrb` in 4, `data_addr` in 32, `data_wdata` in 32.
- `data_addr_ok`, `data_data_ok` out 1 each; `data_rdata` out 32.
- `mem_req`, `mem_wr` out 1 each; `mem_size` out 2, `mem_wstrb` out 4, `mem_addr` out 32, `mem_wdata` out 32.
- `mem_addr_ok`, `mem_data_ok` in 1 each; `mem_rdata` in 32.
- `busy` out 1: the owner FIFO is non-empty or a grant is locked.

## Operation

**State**
- `lock_v`/`lock_own`: grant lock.
- Owner FIFO: 1 bit per entry (0 = inst, 1 = data), with `wr_ptr`, `rd_ptr` and `cnt`.
- `rr_last`: only when round-robin is compiled in.

**Winner selection**
- If `lock_v` is set, the winner is `lock_own`.
- Otherwise, with both requesters active, the winner is set by policy (see Configuration).
- If only one requester is active, that requester wins.

**Master port**
- `mem_req` = winner's req AND (`cnt` < `MAX_OUTSTANDING`).
- The `mem_*` fields are muxed combinationally from the winner.
- When `mem_req` = 0, the `mem_*` fields still mirror the winner, or the inst port when no requester is active.

**Address handshake**
- The winner's `addr_ok` = `mem_req` & `mem_addr_ok`. The loser's `addr_ok` is 0.
- If `mem_req` & !`mem_addr_ok`: set `lock_v`, set `lock_own` to the winner.
- If `mem_req` & `mem_addr_ok`: clear `lock_v` and push the winner's ID into the owner FIFO.
- If the locked owner drops req (a protocol violation): clear `lock_v` and take no push.

**Response**
- On `mem_data_ok` with `cnt` > 0:
  - assert `data_ok` only toward the owner at the FIFO head;
  - pop the FIFO.
- `inst_rdata` and `data_rdata` both equal `mem_rdata`.
- `mem_data_ok` with `cnt` = 0 is ignored: no output pulse, no state change.

**Counter arithmetic**
- `cnt` is ($clog2(`MAX_OUTSTANDING`)+1) bits wide.
- `cnt` next = `cnt` + push − pop.
- Pointers wrap modulo `MAX_OUTSTANDING`.

## Timing

**Reset**
- On reset: `cnt`=0, pointers=0, `lock_v`=0, `rr_last`=0 (inst).
- While `reset`=1, force `mem_req` and all `addr_ok`/`data_ok` outputs to 0, and force `busy`=0.

**Latency**
- Request to `mem_req` is 0 cycles (combinational).
- `mem_addr_ok` to requester `addr_ok` is same cycle.
- `mem_data_ok` to requester `data_ok` is same cycle.

**Capacity**
- Full: when `cnt` = `MAX_OUTSTANDING`, `mem_req` = 0 even if a pop occurs that cycle. The full check uses registered `cnt`.

**Simultaneous events**
- Push and pop in the same cycle leave `cnt` unchanged and advance both pointers.
- A push and a pop of the same owner in one cycle is legal: `addr_ok` and `data_ok` can both be high toward one requester.

**Grant lock**
- A locked grant is never preempted by the other requester.

**Reset mid-operation**
- Outstanding entries are discarded.
- The downstream side must also be reset.
- Late `mem_data_ok` after reset falls under the `cnt`=0 rule.

## Configuration

- `ARB_RR_EN` defined: round-robin arbitration.
  - On contention, the requester other than `rr_last` wins.
  - `rr_last` updates to the winner on every push.
- `ARB_RR_EN` undefined: fixed priority, data over inst.
  - `rr_last` logic is not compiled.

## Test plan

1. **Single inst read.** `inst_req`=1, addr 0x1c000000, `mem_addr_ok` same cycle, `mem_data_ok` 2 cycles later with rdata 0x02800c0c. Required: `inst_addr_ok` pulse, then `inst_data_ok` with 0x02800c0c. `data_data_ok` stays 0.
2. **Contention, fixed priority (`ARB_RR_EN` undefined).** Both req, with data a store to 0x8000_0010, wstrb 0xF. Required: data granted first (`mem_wr`=1); inst granted the next cycle. Responses are returned to data and then to inst.
3. **Contention, `ARB_RR_EN` defined.** Both req held for 4 accepted transactions. Required: grant order is data, inst, data, inst (`rr_last` starts at inst).
4. **Lock.** Inst wins while `mem_addr_ok`=0 for 3 cycles; data asserts req on cycle 1. Required: `mem_addr` stays the inst address for all 3 cycles; data is granted only after the inst `addr_ok`.
5. **Full and boundary.** `MAX_OUTSTANDING`=2; accept 2 requests and hold `mem_data_ok`=0. Required: `mem_req`=0, `cnt`=2. Then `mem_data_ok`=1 in the same cycle a new request is pending: pop only; the new request is accepted the next cycle.
6. **Reset and spurious response.** Assert `reset` with `cnt`=1, then pulse `mem_data_ok`. Required: no `data_ok` output, `cnt` stays 0, `busy`=0.
